neuron_sequencer: RTL
=====================

// Module: neuron_sequencer
// PURPOSE
//  Layer-level controller that sits between layer activation storage and one shared multiplier.
//  - Captures the layer input activations.
//  - Per neuron: fetches weights and bias from a 1-cycle-latency weight memory, drives the
//    multiplier start/ack/done/ack handshake and stores the activated result in a layer output vector.
//  - Neurons are processed strictly in order 0..NUM_NEURONS-1.
// PARAMETERS
//  NUM_INPUTS   4   activations per neuron; operand bus width is 32*NUM_INPUTS
//  NUM_NEURONS  4   neurons per layer, >=1; weight address width ADDR_W = max(1,$clog2(NUM_NEURONS))
// PORTS
//  clk_i           in   1            single clock, rising edge
//  reset_i         in   1            synchronous, active-high reset
//  layer_start_i   in   1            start request; sampled only in IDLE
//  layer_actv_i    in   32*NUM_INPUTS  input activations; captured on the accepted start cycle
//  layer_busy_o    out  1            high in every state except IDLE
//  layer_done_o    out  1            high in DONE until layer_ack_i
//  layer_ack_i     in   1            consumer acknowledge of layer_done_o
//  layer_actv_o    out  32*NUM_NEURONS  results; neuron n at [32n+:32]
//  wt_rd_en_o      out  1            weight-memory read strobe, 1-cycle pulse
//  wt_rd_addr_o    out  ADDR_W       neuron index being fetched
//  wt_rd_data_i    in   32*NUM_INPUTS  weights, valid the cycle after wt_rd_en_o
//  bias_rd_data_i  in   32           bias, valid with wt_rd_data_i
//  mult_start_o    out  1            to multiplier start_i
//  mult_ack_i      in   1            from multiplier ack_o, 1-cycle pulse
//  mult_actv_o     out  32*NUM_INPUTS  captured activations to multiplier actv_i
//  mult_weights_o  out  32*NUM_INPUTS  latched weights to multiplier weights_i
//  mult_bias_o     out  32           latched bias to multiplier bias_i
//  mult_done_i     in   1            from multiplier done_o; level, held until acked
//  mult_result_i   in   32           from multiplier actv_o; valid while mult_done_i is high
//  mult_ack_o      out  1            to multiplier ack_i, 1-cycle pulse
// BEHAVIOUR
//  Reset: all outputs 0, layer_actv_o 0, operand registers 0, index 0, state IDLE.
//  States and transitions:
//  - IDLE: on layer_start_i, capture layer_actv_i, clear layer_actv_o, idx=0 -> FETCH.
//  - FETCH: wt_rd_en_o=1, wt_rd_addr_o=idx -> WAIT_RD.
//  - WAIT_RD: latch wt_rd_data_i and bias_rd_data_i into operand registers -> START.
//  - START: mult_start_o=1; stays in START while mult_ack_i=0.
//    - Cycle mult_ack_i=1 is sampled: mult_start_o deasserts (registered, low next cycle) -> WAIT_DONE.
//  - WAIT_DONE: on mult_done_i=1, write mult_result_i into slot idx and pulse mult_ack_o for
//    exactly 1 cycle -> NEXT.
//  - NEXT: if idx==NUM_NEURONS-1 -> DONE; else idx++ -> FETCH.
//    - Takes one cycle, so the multiplier's done_o has dropped before the next START.
//  - DONE: layer_done_o=1 -> on layer_ack_i, clear layer_done_o -> IDLE.
//  Operand stability: mult_actv_o, mult_weights_o and mult_bias_o are held constant from START
//    through WAIT_DONE. The multiplier reads them serially over NUM_INPUTS cycles.
//  Ignored inputs:
//    - mult_done_i outside WAIT_DONE; mult_ack_i outside START.
//    - layer_start_i outside IDLE, including the cycle layer_ack_i returns the block to IDLE.
//  layer_actv_o holds its values from DONE until the next accepted layer_start_i.
//  No arithmetic is done here: results are stored verbatim, 32 bits. Index wrap is impossible (NEXT checks the bound).
//  Reset mid-operation: immediate return to IDLE with all outputs 0.
//    - The multiplier shares reset_i, so no handshake is left dangling.
//  Per-neuron latency with the reference multiplier: NUM_INPUTS+8 cycles.
//    Layer latency = NUM_NEURONS*(NUM_INPUTS+8)+1 cycles, layer_start_i to layer_done_o.
// STRUCTURE
//  nn_pkg holds:
//  - DATA_W=32.
//  - typedef enum logic [2:0] st_seq_e {IDLE,FETCH,WAIT_RD,START,WAIT_DONE,NEXT,DONE}.
//  Single FSM plus datapath registers; no sub-module.
//  Bench instantiates multiplier (LAYER=1, ReLU) and a behavioural weight ROM.
// TESTING
//  1. Basic layer, NUM_INPUTS=4, NUM_NEURONS=4, actv {1,2,3,4}:
//     w0={1,1,1,1} b0=0; w1={-1,-1,-1,-1} b1=0; w2={0,0,0,2} b2=5; w3=0 b3=-3
//     -> layer_actv_o slots {10,0,13,0}, layer_done_o after 49 cycles.
//  2. layer_start_i pulsed again during WAIT_DONE of neuron 1 -> ignored.
//     Results as in test 1; exactly 4 wt_rd_en_o pulses.
//  3. Stub multiplier delays ack_o by 5 cycles -> mult_start_o held 5 cycles, deasserts the cycle
//     after ack; operands unchanged throughout.
//  4. reset_i asserted in WAIT_DONE of neuron 2:
//     - next cycle all outputs 0, state IDLE.
//     - a fresh start completes test 1 correctly.
//  5. layer_ack_i delayed 10 cycles -> layer_done_o and layer_actv_o stable for 10 cycles.
//     A layer_start_i in the same cycle as layer_ack_i is ignored.
//  6. NUM_NEURONS=1, w={2,2,2,2} b=1, actv {1,1,1,1} -> slot0=9, wt_rd_addr_o always 0.

Source files
------------

// File: rtl/nn_pkg.sv
// rtl/nn_pkg.sv - shared data width and sequencer state encoding
package nn_pkg;

    localparam int DATA_W = 32;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        WAIT_RD,
        START,
        WAIT_DONE,
        NEXT,
        DONE
    } st_seq_e;

endpackage

// File: rtl/neuron_sequencer.sv
// rtl/neuron_sequencer.sv - layer controller feeding one shared multiplier, neuron by neuron
//
// Captures a layer's input activations, then for each neuron 0..NUM_NEURONS-1:
// fetches weights/bias from a 1-cycle-latency memory, runs the multiplier
// start/ack/done/ack handshake and stores the result verbatim in layer_actv_o.
//
// Ports:
//   clk_i, reset_i                  clock, synchronous active-high reset
//   layer_start_i / layer_actv_i    start request and activations (IDLE only)
//   layer_busy_o / layer_done_o     status; done held until layer_ack_i
//   layer_actv_o                    results, neuron n at [32n+:32]
//   wt_rd_en_o / wt_rd_addr_o       weight memory read strobe and neuron index
//   wt_rd_data_i / bias_rd_data_i   weights and bias, valid the cycle after the strobe
//   mult_start_o / mult_ack_i       multiplier start and its acceptance pulse
//   mult_actv_o / mult_weights_o / mult_bias_o   operands, stable START..WAIT_DONE
//   mult_done_i / mult_result_i     multiplier completion level and result
//   mult_ack_o                      one-cycle acknowledge of mult_done_i
module neuron_sequencer
    import nn_pkg::*;
#(
    parameter  int NUM_INPUTS  = 4,
    parameter  int NUM_NEURONS = 4,
    localparam int ADDR_W      = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1
) (
    input  logic                            clk_i,
    input  logic                            reset_i,
    input  logic                            layer_start_i,
    input  logic [DATA_W*NUM_INPUTS-1:0]    layer_actv_i,
    output logic                            layer_busy_o,
    output logic                            layer_done_o,
    input  logic                            layer_ack_i,
    output logic [DATA_W*NUM_NEURONS-1:0]   layer_actv_o,
    output logic                            wt_rd_en_o,
    output logic [ADDR_W-1:0]               wt_rd_addr_o,
    input  logic [DATA_W*NUM_INPUTS-1:0]    wt_rd_data_i,
    input  logic [DATA_W-1:0]               bias_rd_data_i,
    output logic                            mult_start_o,
    input  logic                            mult_ack_i,
    output logic [DATA_W*NUM_INPUTS-1:0]    mult_actv_o,
    output logic [DATA_W*NUM_INPUTS-1:0]    mult_weights_o,
    output logic [DATA_W-1:0]               mult_bias_o,
    input  logic                            mult_done_i,
    input  logic [DATA_W-1:0]               mult_result_i,
    output logic                            mult_ack_o
);

    st_seq_e                        state;
    st_seq_e                        state_nxt;
    logic [ADDR_W-1:0]              idx;
    logic [DATA_W*NUM_INPUTS-1:0]   actv_q;
    logic [DATA_W*NUM_INPUTS-1:0]   wt_q;
    logic [DATA_W-1:0]              bias_q;
    logic [DATA_W*NUM_NEURONS-1:0]  out_q;
    logic                           last;

    assign last = (idx == ADDR_W'(NUM_NEURONS - 1));

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state  <= IDLE;
            idx    <= '0;
            actv_q <= '0;
            wt_q   <= '0;
            bias_q <= '0;
            out_q  <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (layer_start_i) begin
                        actv_q <= layer_actv_i;
                        out_q  <= '0;
                        idx    <= '0;
                    end
                end
                WAIT_RD: begin
                    wt_q   <= wt_rd_data_i;
                    bias_q <= bias_rd_data_i;
                end
                WAIT_DONE: begin
                    if (mult_done_i) begin
                        for (int n = 0; n < NUM_NEURONS; n++) begin
                            if (idx == ADDR_W'(n)) begin
                                out_q[DATA_W*n +: DATA_W] <= mult_result_i;
                            end
                        end
                    end
                end
                NEXT: begin
                    if (!last) begin
                        idx <= idx + ADDR_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Outputs are decoded from the registered state, so mult_start_o drops the
    // cycle after mult_ack_i is sampled and mult_ack_o is a single NEXT-cycle pulse.
    always_comb begin
        state_nxt    = state;
        layer_busy_o = (state != IDLE);
        layer_done_o = 1'b0;
        wt_rd_en_o   = 1'b0;
        wt_rd_addr_o = '0;
        mult_start_o = 1'b0;
        mult_ack_o   = 1'b0;
        case (state)
            IDLE: begin
                if (layer_start_i) state_nxt = FETCH;
            end
            FETCH: begin
                wt_rd_en_o   = 1'b1;
                wt_rd_addr_o = idx;
                state_nxt    = WAIT_RD;
            end
            WAIT_RD: begin
                state_nxt = START;
            end
            START: begin
                mult_start_o = 1'b1;
                if (mult_ack_i) state_nxt = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (mult_done_i) state_nxt = NEXT;
            end
            NEXT: begin
                // Spending a cycle here lets the multiplier drop done before the next START.
                mult_ack_o = 1'b1;
                state_nxt  = last ? DONE : FETCH;
            end
            DONE: begin
                layer_done_o = 1'b1;
                if (layer_ack_i) state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign layer_actv_o   = out_q;
    assign mult_actv_o    = actv_q;
    assign mult_weights_o = wt_q;
    assign mult_bias_o    = bias_q;

endmodule
